// File: rtl/vga_pkg.sv
// Shared VGA timing and board-geometry constants.
// The timing generator and the draw_square* stages both read this package.
package vga_pkg;

  // Counter width. Each axis total must fit in it.
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  // Default 1024x768@60 timing (65 MHz pixel clock).
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
      axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
      axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Board region drawn by the draw_square* stages: an 8x8 grid centred in the active area.
  localparam int unsigned BOARD_CELLS = 8;
  localparam int unsigned CELL_SIZE   = 64;
  localparam int unsigned BOARD_SIZE  = BOARD_CELLS * CELL_SIZE;
  localparam int unsigned BOARD_XPOS  = (DEF_H_ACTIVE - BOARD_SIZE) / 2;
  localparam int unsigned BOARD_YPOS  = (DEF_V_ACTIVE - BOARD_SIZE) / 2;

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the VGA raster: wrapping position counter plus registered sync/blank flags.
// Flags are derived from the next count so they line up with the registered count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned Total      = DEF_H_TOTAL,
  parameter int unsigned SyncStart  = DEF_H_ACTIVE + DEF_H_FP,
  parameter int unsigned SyncEnd    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC,
  parameter int unsigned BlankStart = DEF_H_ACTIVE,
  parameter bit          SyncLow    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             blank
);

  localparam cnt_t LastC       = cnt_t'(Total - 1);
  localparam cnt_t SyncStartC  = cnt_t'(SyncStart);
  localparam cnt_t SyncEndC    = cnt_t'(SyncEnd);
  localparam cnt_t BlankStartC = cnt_t'(BlankStart);

  cnt_t count_q, count_d;
  logic sync_q, sync_d;
  logic blank_q, blank_d;
  logic last;

  // Next position and the flags that describe it.
  always_comb begin
    last    = (count_q == LastC);
    wrap    = inc & last;
    count_d = count_q;
    if (inc) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
    blank_d = (count_d >= BlankStartC);
    sync_d  = ((count_d >= SyncStartC) && (count_d < SyncEndC)) ^ SyncLow;
  end

  // Count and flags share one register stage; sync resets to its idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= SyncLow;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blank = blank_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing source (default 1024x768@60) feeding the draw_* chain.
// Build option: define VGA_TIMING_SYNC_NEG_EN for active-low hsync/vsync (idle high);
// otherwise syncs are active-high. Counters, blanks and frame_start are unaffected.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

`ifdef VGA_TIMING_SYNC_NEG_EN
  localparam bit SYNC_LOW = 1'b1;
`else
  localparam bit SYNC_LOW = 1'b0;
`endif

  // Refuse to elaborate a mode the 11-bit counters cannot represent.
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_too_big
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  logic h_wrap;
  logic v_wrap;
  logic frame_start_q;

  vga_axis_counter #(
    .Total      (H_TOTAL),
    .SyncStart  (H_ACTIVE + H_FP),
    .SyncEnd    (H_ACTIVE + H_FP + H_SYNC),
    .BlankStart (H_ACTIVE),
    .SyncLow    (SYNC_LOW)
  ) u_hcnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .count (hcount_out),
    .wrap  (h_wrap),
    .sync  (hsync_out),
    .blank (hblnk_out)
  );

  // Vertical axis steps only when the line wraps, so its flags change only at hcount 0.
  vga_axis_counter #(
    .Total      (V_TOTAL),
    .SyncStart  (V_ACTIVE + V_FP),
    .SyncEnd    (V_ACTIVE + V_FP + V_SYNC),
    .BlankStart (V_ACTIVE),
    .SyncLow    (SYNC_LOW)
  ) u_vcnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (vcount_out),
    .wrap  (v_wrap),
    .sync  (vsync_out),
    .blank (vblnk_out)
  );

  // Both axes wrapping together means the next position is (0,0).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1024x768, a tiny mode for whole frames, and 640x480.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_NEG_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } outs_t;

  typedef struct {
    int unsigned n;
    int unsigned sel;  // 0: default mode, 1: 640x480
    outs_t       exp;
  } vec_t;

  logic pclk = 1'b0;
  logic rst_n = 1'b1;

  always #5 pclk = ~pclk;

  logic [10:0] a_h, a_v, s_h, s_v, g_h, g_v;
  logic a_hs, a_vs, a_hb, a_vb, a_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_fs;
  logic g_hs, g_vs, g_hb, g_vb, g_fs;

  vga_timing_gen dut (
    .pclk(pclk), .rst_n(rst_n), .hcount_out(a_h), .vcount_out(a_v), .hsync_out(a_hs),
    .vsync_out(a_vs), .hblnk_out(a_hb), .vblnk_out(a_vb), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .pclk(pclk), .rst_n(rst_n), .hcount_out(s_h), .vcount_out(s_v), .hsync_out(s_hs),
    .vsync_out(s_vs), .hblnk_out(s_hb), .vblnk_out(s_vb), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)
  ) dut_640 (
    .pclk(pclk), .rst_n(rst_n), .hcount_out(g_h), .vcount_out(g_v), .hsync_out(g_hs),
    .vsync_out(g_vs), .hblnk_out(g_hb), .vblnk_out(g_vb), .frame_start(g_fs)
  );

  outs_t oa, os, og;
  assign oa = {a_h, a_v, a_hs, a_vs, a_hb, a_vb, a_fs};
  assign os = {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs};
  assign og = {g_h, g_v, g_hs, g_vs, g_hb, g_vb, g_fs};

  int tests = 0;
  int fails = 0;
  int unsigned n = 0;  // pclk edges since reset release
  int last_fs = -1;

  // Expected outputs n edges after reset release: raster position is just n mod frame size.
  function automatic outs_t model(input int unsigned k,
                                  input int unsigned ha, input int unsigned hf,
                                  input int unsigned hsw, input int unsigned hbp,
                                  input int unsigned va, input int unsigned vf,
                                  input int unsigned vsw, input int unsigned vbp);
    int unsigned ht, vt, h, v;
    outs_t o;
    ht   = ha + hf + hsw + hbp;
    vt   = va + vf + vsw + vbp;
    h    = k % ht;
    v    = (k / ht) % vt;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hb = (h >= ha);
    o.vb = (v >= va);
    o.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ^ NEG;
    o.vs = ((v >= va + vf) && (v < va + vf + vsw)) ^ NEG;
    o.fs = (k != 0) && (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic outs_t m_dflt(input int unsigned k);
    return model(k, 1024, 24, 136, 160, 768, 3, 6, 29);
  endfunction
  function automatic outs_t m_small(input int unsigned k);
    return model(k, 16, 2, 3, 3, 8, 1, 2, 2);
  endfunction
  function automatic outs_t m_640(input int unsigned k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic outs_t mk(input int unsigned h, input int unsigned v, input bit hs,
                               input bit vs, input bit hb, input bit vb, input bit fs);
    outs_t o;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hs = hs ^ NEG;
    o.vs = vs ^ NEG;
    o.hb = hb;
    o.vb = vb;
    o.fs = fs;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
               name, n, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dflt"}, oa, m_dflt(n));
    check({tag, "_small"}, os, m_small(n));
    check({tag, "_640"}, og, m_640(n));
  endtask

  // One pclk edge, then sample 1 ns later and compare every instance to the model.
  task automatic step();
    @(posedge pclk);
    #1;
    n++;
    check_all("run");
    if (os.fs === 1'b1) begin
      if (last_fs >= 0) begin
        tests++;
        if (int'(n) - last_fs != 312) begin
          fails++;
          $display("FAIL fs_period got=%0d want=312", int'(n) - last_fs);
        end
      end
      last_fs = int'(n);
    end
  endtask

  // Assert reset mid-cycle, confirm outputs clear before the next edge, hold, release.
  task automatic reset_pulse(input int unsigned offset, input int unsigned hold);
    #(offset);
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all("async_rst");
    repeat (hold) begin
      @(posedge pclk);
      #1;
      check_all("in_rst");
    end
    rst_n = 1'b1;
    n = 0;
    last_fs = -1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1,    0, mk(1,    0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{655,  1, mk(655,  0, 0, 0, 1, 0, 0)};
    tbl[2]  = '{656,  1, mk(656,  0, 1, 0, 1, 0, 0)};
    tbl[3]  = '{751,  1, mk(751,  0, 1, 0, 1, 0, 0)};
    tbl[4]  = '{752,  1, mk(752,  0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{799,  1, mk(799,  0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{800,  1, mk(0,    1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1023, 0, mk(1023, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1024, 0, mk(1024, 0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{1047, 0, mk(1047, 0, 0, 0, 1, 0, 0)};
    tbl[10] = '{1048, 0, mk(1048, 0, 1, 0, 1, 0, 0)};
    tbl[11] = '{1183, 0, mk(1183, 0, 1, 0, 1, 0, 0)};
    tbl[12] = '{1184, 0, mk(1184, 0, 0, 0, 1, 0, 0)};
    tbl[13] = '{1343, 0, mk(1343, 0, 0, 0, 1, 0, 0)};
    tbl[14] = '{1344, 0, mk(0,    1, 0, 0, 0, 0, 0)};
    tbl[15] = '{2700, 0, mk(12,   2, 0, 0, 0, 0, 0)};

    // Power-on reset held for 5 edges.
    #1;
    rst_n = 1'b0;
    #1;
    check_all("por");
    repeat (5) begin
      @(posedge pclk);
      #1;
      check_all("por_hold");
    end
    rst_n = 1'b1;
    n = 0;
    last_fs = -1;

    // Hand-computed points on the first lines of the default and 640x480 modes.
    for (int i = 0; i < 16; i++) begin
      while (n < tbl[i].n) step();
      if (tbl[i].sel == 0) check("tbl_dflt", oa, tbl[i].exp);
      else check("tbl_640", og, tbl[i].exp);
    end
    while (n < 3000) step();

    // Reset the small mode while both of its syncs are active.
    for (int i = 0; i < 400; i++) begin
      outs_t e;
      e = m_small(n);
      if (e.hs == !NEG && e.vs == !NEG) break;
      step();
    end
    check("in_sync_small", os, mk(os.h, os.v, 1, 1, 1, 1, 0));
    reset_pulse(2, 2);
    step();
    check("restart_dflt", oa, mk(1, 0, 0, 0, 0, 0, 0));

    // Random run lengths with asynchronous resets at random points.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(50, 1500)) step();
      reset_pulse($urandom_range(0, 3), $urandom_range(1, 4));
    end
    repeat (400) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA pixel-stream interface that every draw_* stage in the video chain consumes.
- Generates the hcount/vcount counters, the hsync/vsync pulses and the hblnk/vblnk flags for a 1024x768@60 frame on pclk.
- All outputs are registered and mutually coherent: any output cycle describes one pixel position.
- Feeds the first drawing stage (background). Downstream stages add one register of latency each and pass the timing through unchanged.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pclk cycles)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch

Ports:
- pclk  input  1  pixel clock, 65 MHz nominal
- rst_n  input  1  asynchronous active-low reset
- hcount_out  output  11  horizontal position, 0..H_TOTAL-1
- vcount_out  output  11  vertical position, 0..V_TOTAL-1
- hsync_out  output  1  horizontal sync pulse
- vsync_out  output  1  vertical sync pulse
- hblnk_out  output  1  high outside the horizontal active region
- vblnk_out  output  1  high outside the vertical active region
- frame_start  output  1  one-cycle pulse when hcount_out==0 and vcount_out==0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806). Both must be <= 2048; elaboration fails otherwise.
- Reset: asserting rst_n=0 clears all outputs and internal counters to 0 immediately, without waiting for a pclk edge. The first pclk edge after deassertion produces hcount=1, vcount=0.
- Reset mid-frame has the same effect: the frame restarts at (0,0) and no partial sync pulse is held.
- Horizontal counter: increments each cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the horizontal wrap. When vcount==V_TOTAL-1 and the horizontal counter wraps, both counters go to 0 in the same cycle.
- Flags are computed combinationally from the next counter values and registered alongside them, so there is zero skew between the count outputs and the flags:
  - hblnk = (hcount >= H_ACTIVE)
  - hsync = (H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC)
  - vblnk = (vcount >= V_ACTIVE)
  - vsync = (V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC)
- vsync and vblnk change only in the cycle where hcount_out==0. They are held for whole lines.
- frame_start is high for exactly one cycle per frame: every 1083264 cycles with default parameters. It is also high in the first cycle after reset only if the counters are at (0,0) then; since the first post-reset cycle is hcount=1, it is not asserted until the first wrap.
- No handshake: the stream is free-running and downstream stages cannot stall it.
- All arithmetic uses 11-bit unsigned values; comparisons are against parameter-derived constants only.

Optional Feature:
- Macro: VGA_TIMING_SYNC_NEG_EN.
- Defined: hsync_out and vsync_out are driven active-low (idle 1, pulse 0), matching the VESA 1024x768 polarity for direct pin drive. Reset value of both syncs becomes 1.
- Undefined: syncs are active-high (idle 0) with reset value 0. This is the polarity every existing draw stage and the top-level pin inversion expect.
- Counters, blanking flags and frame_start are identical in both builds.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants (H_ACTIVE through V_BP)
  - derived H_TOTAL and V_TOTAL
  - the counter width localparam (11)
  - the board-region constants used by the draw_square* stages, so geometry and timing share one source
- One sub-module is natural: vga_axis_counter (parameterised total, sync start/end, blank start). It is instantiated twice, with the horizontal instance's wrap output driving the vertical instance's increment enable.

Test Plan:
- Hold rst_n=0 for 5 cycles, then release -> all outputs 0 during reset; first edge gives hcount=1, vcount=0, hblnk=0, hsync=0.
- Run one line -> hblnk rises at hcount=1024; hsync high for hcount 1048..1183 (136 cycles); hcount wraps 1343->0 and vcount increments 0->1 in the same cycle.
- Run one full frame -> vblnk high for vcount 768..805; vsync high for vcount 771..776 (6 lines); frame_start pulses once; cycle count between frame_start pulses is 1083264.
- Pulse rst_n low at hcount=1100, vcount=772 (mid hsync/vsync) -> all outputs drop to 0 asynchronously before the next pclk edge; timing restarts at (0,0).
- Build with VGA_TIMING_SYNC_NEG_EN -> syncs reset to 1; hsync low exactly for hcount 1048..1183; counters and blanks match the default build cycle for cycle.
- Override parameters to 640x480 (H 640/16/96/48, V 480/10/2/33) -> wrap at hcount 799 and vcount 524; hsync spans 656..751; vsync spans lines 490..491.
